// File: rtl/data_mem_pipe.sv
// -----------------------------------------------------------------------------
// data_mem_pipe
//   Byte-addressed data memory for the 24-bit MIPS datapath. One request per
//   cycle is taken on a valid/ready port. Writes honour per-byte enables. Every
//   accepted request returns exactly one response after READ_LATENCY cycles, in
//   acceptance order. A request that is misaligned or past the end of memory is
//   flagged with rsp_err and never touches storage. After reset the block sweeps
//   zeros through every word (INIT) before it starts accepting requests (RUN).
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle (RUN state only)
//   req_we     1 = write, 0 = read
//   req_addr   byte address; word index = req_addr / BYTES
//   req_wdata  write data
//   req_be     byte enables, bit i covers req_wdata[8i+7:8i]
//   rsp_valid  one-cycle response strobe
//   rsp_we     request type echoed back with the response
//   rsp_rdata  read data (zero for writes and errored requests)
//   rsp_err    request was misaligned or out of range
// -----------------------------------------------------------------------------
module data_mem_pipe #(
  parameter int DATA_WIDTH   = 24,
  parameter int DEPTH        = 64,
  parameter int ADDR_WIDTH   = 24,
  parameter int READ_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_be,
  output logic                      rsp_valid,
  output logic                      rsp_we,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  // One slot of the response shift pipeline.
  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      clear_ptr_q, clear_ptr_d;
  rsp_t                  pipe_q [READ_LATENCY];
  rsp_t                  pipe_d [READ_LATENCY];
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Request decode. The divide/modulo run at full address width so a large
  // address can never alias onto a valid word.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [ADDR_WIDTH-1:0] byte_off;
  logic [IDX_W-1:0]      req_idx;
  logic                  req_err;
  logic                  accept;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;

  assign word_addr = req_addr / ADDR_WIDTH'(BYTES);
  assign byte_off  = req_addr % ADDR_WIDTH'(BYTES);
  assign req_err   = (byte_off != '0) || (word_addr >= ADDR_WIDTH'(DEPTH));
  assign req_idx   = word_addr[IDX_W-1:0];
  assign accept    = req_valid && req_ready;
  assign old_word  = mem_q[req_idx];

  // Byte-enable merge of new data over the stored word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    merged_word = old_word;
    for (int b = 0; b < BYTES; b++) begin
      if (req_be[b]) merged_word[8*b +: 8] = req_wdata[8*b +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: INIT sweeps zeros through memory, RUN accepts requests.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    req_ready   = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        clear_ptr_d = clear_ptr_q + IDX_W'(1);
        if (clear_ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d     = ST_RUN;
          clear_ptr_d = '0;
        end
      end
      ST_RUN: begin
        // Ready drops during a reset cycle so nothing is accepted on a reset edge.
        req_ready = rst_n;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Single write port shared by the INIT sweep and accepted writes.
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if (state_q == ST_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = clear_ptr_q;
      end else if (accept && req_we && !req_err) begin
        mem_we    = 1'b1;
        mem_waddr = req_idx;
        mem_wdata = merged_word;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline: stage 0 captures the request at the acceptance edge;
  // read data reflects memory contents before that edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    pipe_d[0] = '0;
    if (accept) begin
      pipe_d[0].valid = 1'b1;
      pipe_d[0].we    = req_we;
      pipe_d[0].err   = req_err;
      pipe_d[0].data  = (req_we || req_err) ? '0 : old_word;
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state_q     <= ST_INIT;
      clear_ptr_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // NOTE: storage has no reset; the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rsp_valid = pipe_q[READ_LATENCY-1].valid;
  assign rsp_we    = pipe_q[READ_LATENCY-1].we;
  assign rsp_err   = pipe_q[READ_LATENCY-1].err;
  assign rsp_rdata = pipe_q[READ_LATENCY-1].data;

endmodule

// File: tb/tb_data_mem_pipe.sv
// -----------------------------------------------------------------------------
// tb_data_mem_pipe
//   Directed bench for data_mem_pipe. Three instances (READ_LATENCY 2, 1, 4)
//   share one stimulus stream, so their memories stay identical and each can be
//   checked against its own response timing. Inputs change on the falling edge,
//   outputs are sampled on the falling edge just before new inputs are driven.
// -----------------------------------------------------------------------------
module tb_data_mem_pipe;

  localparam int MAXN = 8;
  localparam int MAXC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [23:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  req_be;

  // Index 0: latency 2, index 1: latency 1, index 2: latency 4.
  logic [2:0]       rdy, rv, rwe, rerr;
  logic [2:0][23:0] rrd;
  int               lat [3] = '{2, 1, 4};

  int checks   = 0;
  int failures = 0;

  data_mem_pipe #(.READ_LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv[0]), .rsp_we(rwe[0]), .rsp_rdata(rrd[0]), .rsp_err(rerr[0])
  );
  data_mem_pipe #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv[1]), .rsp_we(rwe[1]), .rsp_rdata(rrd[1]), .rsp_err(rerr[1])
  );
  data_mem_pipe #(.READ_LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv[2]), .rsp_we(rwe[2]), .rsp_rdata(rrd[2]), .rsp_err(rerr[2])
  );

  // Request list for a sequence and its hand-computed responses.
  logic        q_we    [MAXN];
  logic [23:0] q_addr  [MAXN];
  logic [23:0] q_wdata [MAXN];
  logic [2:0]  q_be    [MAXN];
  logic [23:0] e_rd    [MAXN];
  logic        e_err   [MAXN];
  // Observed {valid, we, err, rdata} per instance per sampled cycle.
  logic [26:0] trace   [3][MAXC];

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  task automatic put(input int i, input logic we, input logic [23:0] a,
                     input logic [23:0] wd, input logic [2:0] be,
                     input logic [23:0] erd, input logic eerr);
    q_we[i] = we; q_addr[i] = a; q_wdata[i] = wd; q_be[i] = be;
    e_rd[i] = erd; e_err[i] = eerr;
  endtask

  // Drives n requests back-to-back, then idles while recording outputs.
  // Request i shows up at trace slot i + latency.
  task automatic run_seq(input int n);
    for (int j = 0; j < n + 6; j++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) trace[d][j] = {rv[d], rwe[d], rerr[d], rrd[d]};
      if (j < n) begin
        req_valid = 1'b1;
        req_we    = q_we[j];
        req_addr  = q_addr[j];
        req_wdata = q_wdata[j];
        req_be    = q_be[j];
      end else begin
        idle();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    checks++;
    if ({rdy, rv, rwe, rerr, rrd} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b v=%b we=%b err=%b rd=%h required all zero",
               rdy, rv, rwe, rerr, rrd);
    end
    rst_n = 1'b1;
    // Ready must stay low for 64 cycles after release, then go high.
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      checks++;
      if ({rdy, rv} !== {{3{c == 64}}, 3'b000}) begin
        failures++;
        $display("FAIL init_ready cycle=%0d got rdy=%b v=%b required rdy=%b v=000",
                 c, rdy, rv, {3{c == 64}});
      end
    end
    put(0, 1'b0, 24'd0,   '0, 3'b000, 24'h0, 1'b0);
    put(1, 1'b0, 24'd3,   '0, 3'b000, 24'h0, 1'b0);
    put(2, 1'b0, 24'd189, '0, 3'b000, 24'h0, 1'b0);
    run_seq(3);
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 9; j++) begin
        int i;
        logic [26:0] exp;
        i = j - lat[d];
        exp = (i >= 0 && i < 3) ? {1'b1, q_we[i], e_err[i], e_rd[i]} : 27'd0;
        checks++;
        if (trace[d][j] !== exp) begin
          failures++;
          $display("FAIL cleared_read lat=%0d slot=%0d got=%h required=%h", lat[d], j, trace[d][j], exp);
        end
      end
    end
  endtask

  task automatic test_write_read();
    put(0, 1'b1, 24'd0, 24'h000064, 3'b111, 24'h0, 1'b0);
    put(1, 1'b1, 24'd3, 24'h0000C8, 3'b111, 24'h0, 1'b0);
    put(2, 1'b1, 24'd6, 24'h00012C, 3'b111, 24'h0, 1'b0);
    put(3, 1'b0, 24'd0, '0, 3'b000, 24'h000064, 1'b0);
    put(4, 1'b0, 24'd3, '0, 3'b000, 24'h0000C8, 1'b0);
    put(5, 1'b0, 24'd6, '0, 3'b000, 24'h00012C, 1'b0);
    run_seq(6);
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 12; j++) begin
        int i;
        logic [26:0] exp;
        i = j - lat[d];
        exp = (i >= 0 && i < 6) ? {1'b1, q_we[i], e_err[i], e_rd[i]} : 27'd0;
        checks++;
        if (trace[d][j] !== exp) begin
          failures++;
          $display("FAIL write_read lat=%0d slot=%0d got=%h required=%h", lat[d], j, trace[d][j], exp);
        end
      end
    end
  endtask

  task automatic test_byte_enable();
    put(0, 1'b1, 24'd9,  24'hAABBCC, 3'b111, 24'h0, 1'b0);
    put(1, 1'b1, 24'd9,  24'h112233, 3'b010, 24'h0, 1'b0);
    put(2, 1'b0, 24'd9,  '0, 3'b000, 24'hAA22CC, 1'b0);
    put(3, 1'b1, 24'd12, 24'hFFFFFF, 3'b000, 24'h0, 1'b0);
    put(4, 1'b0, 24'd12, '0, 3'b000, 24'h000000, 1'b0);
    run_seq(5);
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 11; j++) begin
        int i;
        logic [26:0] exp;
        i = j - lat[d];
        exp = (i >= 0 && i < 5) ? {1'b1, q_we[i], e_err[i], e_rd[i]} : 27'd0;
        checks++;
        if (trace[d][j] !== exp) begin
          failures++;
          $display("FAIL byte_enable lat=%0d slot=%0d got=%h required=%h", lat[d], j, trace[d][j], exp);
        end
      end
    end
  endtask

  task automatic test_errors();
    // 192/3 = 64 would alias onto word 0 if the index were truncated;
    // 4 is misaligned and would land on word 1 (address 3) if the offset were dropped.
    put(0, 1'b0, 24'd4,      '0,         3'b000, 24'h0,      1'b1);
    put(1, 1'b0, 24'd192,    '0,         3'b000, 24'h0,      1'b1);
    put(2, 1'b1, 24'd192,    24'hFFFFFF, 3'b111, 24'h0,      1'b1);
    put(3, 1'b1, 24'd4,      24'hFFFFFF, 3'b111, 24'h0,      1'b1);
    put(4, 1'b0, 24'd0,      '0,         3'b000, 24'h000064, 1'b0);
    put(5, 1'b0, 24'd3,      '0,         3'b000, 24'h0000C8, 1'b0);
    put(6, 1'b0, 24'd189,    '0,         3'b000, 24'h000000, 1'b0);
    put(7, 1'b0, 24'hFFFFFF, '0,         3'b000, 24'h0,      1'b1);
    run_seq(8);
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 14; j++) begin
        int i;
        logic [26:0] exp;
        i = j - lat[d];
        exp = (i >= 0 && i < 8) ? {1'b1, q_we[i], e_err[i], e_rd[i]} : 27'd0;
        checks++;
        if (trace[d][j] !== exp) begin
          failures++;
          $display("FAIL errors lat=%0d slot=%0d got=%h required=%h", lat[d], j, trace[d][j], exp);
        end
      end
    end
  endtask

  task automatic test_read_after_write();
    put(0, 1'b1, 24'd15, 24'h00ABCD, 3'b111, 24'h0,      1'b0);
    put(1, 1'b0, 24'd15, '0,         3'b000, 24'h00ABCD, 1'b0);
    run_seq(2);
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 8; j++) begin
        int i;
        logic [26:0] exp;
        i = j - lat[d];
        exp = (i >= 0 && i < 2) ? {1'b1, q_we[i], e_err[i], e_rd[i]} : 27'd0;
        checks++;
        if (trace[d][j] !== exp) begin
          failures++;
          $display("FAIL read_after_write lat=%0d slot=%0d got=%h required=%h", lat[d], j, trace[d][j], exp);
        end
      end
    end
  endtask

  task automatic test_reset_in_flight();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'd0; req_be = '0;
    @(negedge clk);
    req_addr = 24'd3;
    @(negedge clk);
    // Latency 2 has delivered read 0, latency 1 has delivered read 3,
    // latency 4 still holds both reads.
    checks++;
    if ({rv, rrd[0], rrd[1]} !== {3'b011, 24'h000064, 24'h0000C8}) begin
      failures++;
      $display("FAIL pre_reset got v=%b rd0=%h rd1=%h required v=011 rd0=000064 rd1=0000c8",
               rv, rrd[0], rrd[1]);
    end
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({rdy, rv, rwe, rerr, rrd} !== '0) begin
      failures++;
      $display("FAIL flush_outputs got rdy=%b v=%b we=%b err=%b rd=%h required all zero",
               rdy, rv, rwe, rerr, rrd);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      checks++;
      if ({rdy, rv} !== {{3{c == 64}}, 3'b000}) begin
        failures++;
        $display("FAIL reinit_ready cycle=%0d got rdy=%b v=%b required rdy=%b v=000",
                 c, rdy, rv, {3{c == 64}});
      end
    end
    put(0, 1'b0, 24'd0, '0, 3'b000, 24'h0, 1'b0);
    put(1, 1'b0, 24'd3, '0, 3'b000, 24'h0, 1'b0);
    put(2, 1'b0, 24'd9, '0, 3'b000, 24'h0, 1'b0);
    run_seq(3);
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 9; j++) begin
        int i;
        logic [26:0] exp;
        i = j - lat[d];
        exp = (i >= 0 && i < 3) ? {1'b1, q_we[i], e_err[i], e_rd[i]} : 27'd0;
        checks++;
        if (trace[d][j] !== exp) begin
          failures++;
          $display("FAIL post_reset_read lat=%0d slot=%0d got=%h required=%h", lat[d], j, trace[d][j], exp);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_read_after_write();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
